ab_tile_streamer: RTL and testbench

- Upstream feeder for the matrix-multiply top.
- Reads A and B (row-major, N x N, DATA_WIDTH-bit elements) from two 1-cycle-latency synchronous RAMs.
- Emits the tiled A/B beat stream the PE array consumes: for i < N/Si, j < N/Sj, n < N, ii < Si: A = A[i*Si+ii][n], B = B[n][j*Si+ii].
- A and B leave as a lock-stepped pair under valid/ready, through a 2-entry output FIFO for backpressure.

---
 rtl/ab_tile_streamer.sv | 259 +++++++++++++++++++++++++
 tb/tb_ab_tile_streamer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ab_tile_streamer.sv
// rtl/ab_tile_streamer.sv - tiled A/B beat streamer feeding the matrix-multiply PE array
//
// Reads two row-major N x N matrices from 1-cycle-latency RAMs and emits, for
// each (i, j) tile and each n, Si beats of A[i*Si+ii][n] paired with
// B[n][j*Si+ii]. Beats leave lock-stepped through a 2-entry output FIFO.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-low reset
//   start, N_in        job start pulse (sampled in IDLE) and matrix dimension
//   A_rd_en/addr/data  A RAM read port (data one cycle after the strobe)
//   B_rd_en/addr/data  B RAM read port (strobe identical to A_rd_en)
//   A_out, A_valid_out A beat towards the PE array
//   B_out, B_valid_out B beat towards the PE array (valid identical to A)
//   out_ready          downstream accept
//   busy, done, err    job in progress, end-of-job pulse, sticky config error
module ab_tile_streamer #(
    parameter int DATA_WIDTH  = 64,
    parameter int A_NUM_WIDTH = 3,
    parameter int B_NUM_WIDTH = 3,
    parameter int N_MAX_WIDTH = 32,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_MAX_WIDTH-1:0] N_in,
    output logic                   A_rd_en,
    output logic [ADDR_WIDTH-1:0]  A_rd_addr,
    input  logic [DATA_WIDTH-1:0]  A_rd_data,
    output logic                   B_rd_en,
    output logic [ADDR_WIDTH-1:0]  B_rd_addr,
    input  logic [DATA_WIDTH-1:0]  B_rd_data,
    output logic [DATA_WIDTH-1:0]  A_out,
    output logic                   A_valid_out,
    output logic [DATA_WIDTH-1:0]  B_out,
    output logic                   B_valid_out,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int PW = 2 * N_MAX_WIDTH;
    localparam logic [PW-1:0] ADDR_SPACE = PW'(1) << ADDR_WIDTH;

    // The PE array pairs A rows with B columns one-to-one inside a tile.
    generate
        if (A_NUM_WIDTH != B_NUM_WIDTH) begin : g_tile_mismatch
            $error("ab_tile_streamer: A_NUM_WIDTH must equal B_NUM_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Job configuration
    logic [ADDR_WIDTH-1:0] n_reg;     // N
    logic [ADDR_WIDTH-1:0] n_last;    // N-1
    logic [ADDR_WIDTH-1:0] t_last;    // N/Si-1, shared by i and j
    logic [ADDR_WIDTH-1:0] stride;    // Si*N, A address step between i tiles

    // Loop counters and incremental address bases
    logic [A_NUM_WIDTH-1:0] ii;
    logic [ADDR_WIDTH-1:0]  n_idx, j_idx, i_idx;
    logic [ADDR_WIDTH-1:0]  a_tile;   // i*Si*N
    logic [ADDR_WIDTH-1:0]  a_row;    // (i*Si+ii)*N
    logic [ADDR_WIDTH-1:0]  b_row;    // n*N
    logic [ADDR_WIDTH-1:0]  b_col;    // j*Si

    // Output FIFO and RAM pipeline
    logic [DATA_WIDTH-1:0] fa_mem [2];
    logic [DATA_WIDTH-1:0] fb_mem [2];
    logic                  wr_ptr, rd_ptr;
    logic [1:0]            count;
    logic                  inflight;

    logic [PW-1:0]         n_sq;
    logic [ADDR_WIDTH-1:0] n_new;
    logic                  cfg_bad, accept_start;
    logic                  push, pop, issue, last_read;
    logic                  last_ii, last_n, last_j, last_i;
    logic [1:0]            used;
    logic [ADDR_WIDTH-1:0] a_tile_next;

    assign n_sq    = PW'(N_in) * PW'(N_in);
    assign n_new   = N_in[ADDR_WIDTH-1:0];
    assign cfg_bad = (N_in == '0) || (N_in[A_NUM_WIDTH-1:0] != '0) || (n_sq > ADDR_SPACE);
    assign accept_start = (state_q == S_IDLE) && start && !cfg_bad;

    assign push = inflight;
    assign pop  = (count != 2'd0) && out_ready;

    // Entries that will still be held after this cycle: FIFO contents plus the
    // read whose data lands this cycle, minus the beat leaving. A slot freed by
    // a same-cycle pop is reusable at once, which keeps a 1 beat/cycle stream.
    assign used  = count + {1'b0, inflight} - {1'b0, pop};
    assign issue = (state_q == S_RUN) && (used < 2'd2);

    assign last_ii   = &ii;
    assign last_n    = (n_idx == n_last);
    assign last_j    = (j_idx == t_last);
    assign last_i    = (i_idx == t_last);
    assign last_read = issue && last_ii && last_n && last_j && last_i;

    assign a_tile_next = a_tile + stride;

    assign A_rd_addr = a_row + n_idx;
    assign B_rd_addr = b_row + b_col + ADDR_WIDTH'(ii);

    assign A_out       = fa_mem[rd_ptr];
    assign B_out       = fb_mem[rd_ptr];
    assign A_valid_out = (count != 2'd0);
    assign B_valid_out = (count != 2'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        A_rd_en = 1'b0;
        B_rd_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                A_rd_en = issue;
                B_rd_en = issue;
                if (last_read) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                // Nothing can be issued here, so used==0 means FIFO empty and
                // nothing in flight once this cycle's pop completes.
                if (used == 2'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            err <= cfg_bad;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_reg  <= '0;
            n_last <= '0;
            t_last <= '0;
            stride <= '0;
            ii     <= '0;
            n_idx  <= '0;
            j_idx  <= '0;
            i_idx  <= '0;
            a_tile <= '0;
            a_row  <= '0;
            b_row  <= '0;
            b_col  <= '0;
        end else if (accept_start) begin
            n_reg  <= n_new;
            n_last <= n_new - ADDR_WIDTH'(1);
            t_last <= (n_new >> A_NUM_WIDTH) - ADDR_WIDTH'(1);
            stride <= n_new << A_NUM_WIDTH;
            ii     <= '0;
            n_idx  <= '0;
            j_idx  <= '0;
            i_idx  <= '0;
            a_tile <= '0;
            a_row  <= '0;
            b_row  <= '0;
            b_col  <= '0;
        end else if (issue) begin
            if (!last_ii) begin
                ii    <= ii + A_NUM_WIDTH'(1);
                a_row <= a_row + n_reg;
            end else begin
                ii <= '0;
                if (!last_n) begin
                    n_idx <= n_idx + ADDR_WIDTH'(1);
                    b_row <= b_row + n_reg;
                    a_row <= a_tile;
                end else begin
                    n_idx <= '0;
                    b_row <= '0;
                    if (!last_j) begin
                        j_idx <= j_idx + ADDR_WIDTH'(1);
                        b_col <= b_col + ADDR_WIDTH'(1 << A_NUM_WIDTH);
                        a_row <= a_tile;
                    end else begin
                        j_idx <= '0;
                        b_col <= '0;
                        if (!last_i) begin
                            i_idx  <= i_idx + ADDR_WIDTH'(1);
                            a_tile <= a_tile_next;
                            a_row  <= a_tile_next;
                        end else begin
                            i_idx  <= '0;
                            a_tile <= '0;
                            a_row  <= '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                fa_mem[k] <= '0;
                fb_mem[k] <= '0;
            end
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (push) begin
                fa_mem[wr_ptr] <= A_rd_data;
                fb_mem[wr_ptr] <= B_rd_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_ab_tile_streamer.sv
// tb/tb_ab_tile_streamer.sv - self-checking bench for ab_tile_streamer
module tb_ab_tile_streamer;

    localparam int DW = 64;
    localparam int AN = 3;
    localparam int NW = 32;
    localparam int AW = 16;
    localparam int SI = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [NW-1:0] N_in = '0;
    logic          A_rd_en, B_rd_en;
    logic [AW-1:0] A_rd_addr, B_rd_addr;
    logic [DW-1:0] A_rd_data = '0;
    logic [DW-1:0] B_rd_data = '0;
    logic [DW-1:0] A_out, B_out;
    logic          A_valid_out, B_valid_out;
    logic          out_ready = 1'b1;
    logic          busy, done, err;

    always #5 clk = ~clk;

    ab_tile_streamer #(
        .DATA_WIDTH (DW),
        .A_NUM_WIDTH(AN),
        .B_NUM_WIDTH(AN),
        .N_MAX_WIDTH(NW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .N_in       (N_in),
        .A_rd_en    (A_rd_en),
        .A_rd_addr  (A_rd_addr),
        .A_rd_data  (A_rd_data),
        .B_rd_en    (B_rd_en),
        .B_rd_addr  (B_rd_addr),
        .B_rd_data  (B_rd_data),
        .A_out      (A_out),
        .A_valid_out(A_valid_out),
        .B_out      (B_out),
        .B_valid_out(B_valid_out),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // 1-cycle-latency synchronous RAMs
    logic [DW-1:0] ram_a [0:65535];
    logic [DW-1:0] ram_b [0:65535];
    always @(posedge clk) begin
        if (A_rd_en) A_rd_data <= ram_a[A_rd_addr];
        if (B_rd_en) B_rd_data <= ram_b[B_rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Reference beat order, expressed as RAM addresses
    int      exp_aa[$];
    int      exp_ba[$];
    int      iss_aa [0:4095];
    int      iss_ba [0:4095];
    int      issue_idx, beat_idx;
    int      first_acc_edge, last_acc_edge;
    bit      mon_en = 0;
    bit      stalled_prev;
    logic [DW-1:0] prev_a, prev_b;

    task automatic build_model(input int n);
        exp_aa.delete();
        exp_ba.delete();
        for (int k = 0; k < n * n; k++) begin
            ram_a[k] = {$urandom, $urandom};
            ram_b[k] = {$urandom, $urandom};
        end
        for (int i = 0; i < n / SI; i++)
            for (int j = 0; j < n / SI; j++)
                for (int nn = 0; nn < n; nn++)
                    for (int ii = 0; ii < SI; ii++) begin
                        exp_aa.push_back((i * SI + ii) * n + nn);
                        exp_ba.push_back(nn * n + j * SI + ii);
                    end
        issue_idx = 0;
        beat_idx = 0;
        first_acc_edge = -1;
        last_acc_edge = -1;
        stalled_prev = 0;
        mon_en = 1;
    endtask

    // Stream scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            bit acc;
            acc = A_valid_out && out_ready;
            checks++;
            if (B_rd_en !== A_rd_en || B_valid_out !== A_valid_out) begin
                errors++;
                $display("FAIL lockstep rd_en A=%b B=%b valid A=%b B=%b", A_rd_en, B_rd_en, A_valid_out, B_valid_out);
            end
            if (A_rd_en) begin
                checks++;
                if (issue_idx - beat_idx - int'(acc) >= 2) begin
                    errors++;
                    $display("FAIL issue_limit read %0d with %0d held after pop, need <2", issue_idx, issue_idx - beat_idx - int'(acc));
                end
                checks++;
                if (issue_idx >= exp_aa.size()) begin
                    errors++;
                    $display("FAIL extra_read read %0d addr A=%0d B=%0d, expected only %0d reads", issue_idx, A_rd_addr, B_rd_addr, exp_aa.size());
                end else if (A_rd_addr !== AW'(exp_aa[issue_idx]) || B_rd_addr !== AW'(exp_ba[issue_idx])) begin
                    errors++;
                    $display("FAIL rd_addr read %0d got A=%0d B=%0d, expected A=%0d B=%0d", issue_idx, A_rd_addr, B_rd_addr, exp_aa[issue_idx], exp_ba[issue_idx]);
                end
                if (issue_idx < 4096) begin
                    iss_aa[issue_idx] = int'(A_rd_addr);
                    iss_ba[issue_idx] = int'(B_rd_addr);
                end
                issue_idx++;
            end
            if (stalled_prev) begin
                checks++;
                if (!A_valid_out || A_out !== prev_a || B_out !== prev_b) begin
                    errors++;
                    $display("FAIL stall_hold beat %0d got valid=%b A=%h B=%h, expected valid=1 A=%h B=%h", beat_idx, A_valid_out, A_out, B_out, prev_a, prev_b);
                end
            end
            if (acc) begin
                checks++;
                if (beat_idx >= exp_aa.size()) begin
                    errors++;
                    $display("FAIL extra_beat beat %0d accepted, expected only %0d", beat_idx, exp_aa.size());
                end else if (A_out !== ram_a[exp_aa[beat_idx]] || B_out !== ram_b[exp_ba[beat_idx]]) begin
                    errors++;
                    $display("FAIL beat_data beat %0d got A=%h B=%h, expected A=%h B=%h", beat_idx, A_out, B_out, ram_a[exp_aa[beat_idx]], ram_b[exp_ba[beat_idx]]);
                end
                if (beat_idx == 0) first_acc_edge = cyc + 1;
                last_acc_edge = cyc + 1;
                beat_idx++;
            end
            stalled_prev = A_valid_out && !out_ready;
            prev_a = A_out;
            prev_b = B_out;
        end
    end

    // Drives out_ready per mode and watches done; comparisons stay in the tests.
    // mode 0: ready high, 1: fixed stall pattern, 2: random, 3: ready high and
    // a second start at beat 50. stop_beat >= 0 returns early at that beat.
    task automatic run_job(input int max_cyc, input int mode, input int stop_beat,
                           output int done_cnt, output int done_edge,
                           output bit busy_at_done, output bit timed_out);
        int stall_left = 0;
        bit stalled_once = 0;
        bit restarted = 0;
        int tail = -1;
        done_cnt = 0;
        done_edge = -1;
        busy_at_done = 1'b1;
        timed_out = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = cyc;
                    busy_at_done = busy;
                    tail = 4;
                end
            end
            if (tail > 0) begin
                tail--;
                if (tail == 0) begin
                    timed_out = 1'b0;
                    break;
                end
            end
            if (stop_beat >= 0 && beat_idx >= stop_beat) begin
                timed_out = 1'b0;
                break;
            end
            if (mode == 1) begin
                if (!stalled_once && beat_idx >= 100) begin
                    stalled_once = 1;
                    stall_left = 5;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                end else if (beat_idx >= 300 && beat_idx <= 320) begin
                    out_ready = ~out_ready;
                end else begin
                    out_ready = 1'b1;
                end
            end else if (mode == 2) begin
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (mode == 3 && !restarted && beat_idx >= 50) begin
                restarted = 1;
                N_in = 8;
                start = 1'b1;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({A_rd_en, B_rd_en, A_valid_out, B_valid_out, busy, done, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b, expected 0", {A_rd_en, B_rd_en, A_valid_out, B_valid_out, busy, done, err});
        end
        checks++;
        if (A_rd_addr !== '0 || B_rd_addr !== '0 || A_out !== '0 || B_out !== '0) begin
            errors++;
            $display("FAIL reset_data got addrA=%0d addrB=%0d A=%h B=%h, expected all 0", A_rd_addr, B_rd_addr, A_out, B_out);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic;
        int dc, de;
        bit bd, to;
        build_model(16);
        @(posedge clk);
        #1;
        N_in = 16;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || A_rd_en !== 1'b1 || A_rd_addr !== '0 || B_rd_addr !== '0) begin
            errors++;
            $display("FAIL basic_first_read got busy=%b rd_en=%b A=%0d B=%0d, expected 1 1 0 0", busy, A_rd_en, A_rd_addr, B_rd_addr);
        end
        run_job(2000, 0, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 512 || issue_idx != 512) begin
            errors++;
            $display("FAIL basic_count got timeout=%b beats=%0d reads=%0d, expected 0 512 512", to, beat_idx, issue_idx);
        end
        checks++;
        if (dc != 1 || de != last_acc_edge || bd !== 1'b0) begin
            errors++;
            $display("FAIL basic_done got pulses=%0d at edge %0d busy=%b, expected 1 at edge %0d busy=0", dc, de, bd, last_acc_edge);
        end
        checks++;
        if (last_acc_edge - first_acc_edge != 511) begin
            errors++;
            $display("FAIL basic_throughput got %0d edges for 512 beats, expected 511", last_acc_edge - first_acc_edge);
        end
        checks++;
        if (iss_aa[1] != 16 || iss_ba[1] != 1 || iss_aa[8] != 1 || iss_ba[8] != 16) begin
            errors++;
            $display("FAIL basic_addr_1_8 got %0d/%0d %0d/%0d, expected 16/1 1/16", iss_aa[1], iss_ba[1], iss_aa[8], iss_ba[8]);
        end
        checks++;
        if (iss_aa[128] != 0 || iss_ba[128] != 8 || iss_aa[256] != 128 || iss_ba[256] != 0 || iss_aa[511] != 255 || iss_ba[511] != 255) begin
            errors++;
            $display("FAIL basic_addr_tiles got %0d/%0d %0d/%0d %0d/%0d, expected 0/8 128/0 255/255",
                     iss_aa[128], iss_ba[128], iss_aa[256], iss_ba[256], iss_aa[511], iss_ba[511]);
        end
    endtask

    task automatic test_backpressure;
        int dc, de;
        bit bd, to;
        build_model(16);
        @(posedge clk);
        #1;
        N_in = 16;
        start = 1'b1;
        run_job(4000, 1, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 512 || dc != 1 || de != last_acc_edge) begin
            errors++;
            $display("FAIL stall_run got timeout=%b beats=%0d done=%0d edge=%0d, expected 0 512 1 %0d", to, beat_idx, dc, de, last_acc_edge);
        end
        build_model(8);
        @(posedge clk);
        #1;
        N_in = 8;
        start = 1'b1;
        run_job(2000, 2, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 64 || issue_idx != 64 || dc != 1) begin
            errors++;
            $display("FAIL random_ready got timeout=%b beats=%0d reads=%0d done=%0d, expected 0 64 64 1", to, beat_idx, issue_idx, dc);
        end
    endtask

    task automatic test_bad_cfg;
        int bad_n [4] = '{12, 0, 264, 512};
        int dc, de;
        bit bd, to;
        for (int t = 0; t < 4; t++) begin
            build_model(0);
            @(posedge clk);
            #1;
            N_in = NW'(bad_n[t]);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (3) begin
                checks++;
                if (busy !== 1'b0 || err !== 1'b1) begin
                    errors++;
                    $display("FAIL bad_cfg N=%0d got busy=%b err=%b, expected 0 1", bad_n[t], busy, err);
                end
                @(posedge clk);
                #1;
            end
            checks++;
            if (issue_idx != 0) begin
                errors++;
                $display("FAIL bad_cfg_reads N=%0d got %0d reads, expected 0", bad_n[t], issue_idx);
            end
        end
        build_model(8);
        N_in = 8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b busy=%b, expected 0 1", err, busy);
        end
        run_job(1000, 0, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 64 || dc != 1) begin
            errors++;
            $display("FAIL n8_run got timeout=%b beats=%0d done=%0d, expected 0 64 1", to, beat_idx, dc);
        end
        checks++;
        if (iss_aa[63] != 63 || iss_ba[63] != 63 || iss_aa[8] != 1 || iss_ba[8] != 8) begin
            errors++;
            $display("FAIL n8_addr got %0d/%0d %0d/%0d, expected 63/63 1/8", iss_aa[63], iss_ba[63], iss_aa[8], iss_ba[8]);
        end
        // N=256 fills the address space exactly and must be accepted
        mon_en = 0;
        @(posedge clk);
        #1;
        N_in = 256;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL n256_accept got err=%b busy=%b, expected 0 1", err, busy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset_mid;
        int dc, de;
        bit bd, to;
        build_model(16);
        @(posedge clk);
        #1;
        N_in = 16;
        start = 1'b1;
        run_job(2000, 0, 200, dc, de, bd, to);
        mon_en = 0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({A_rd_en, B_rd_en, A_valid_out, B_valid_out, busy, done, err} !== 7'b0 ||
            A_rd_addr !== '0 || B_rd_addr !== '0 || A_out !== '0 || B_out !== '0) begin
            errors++;
            $display("FAIL async_reset got flags=%b A=%0d B=%0d Aout=%h Bout=%h, expected all 0",
                     {A_rd_en, B_rd_en, A_valid_out, B_valid_out, busy, done, err}, A_rd_addr, B_rd_addr, A_out, B_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        build_model(16);
        N_in = 16;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (A_rd_en !== 1'b1 || A_rd_addr !== '0 || B_rd_addr !== '0) begin
            errors++;
            $display("FAIL restart_first got rd_en=%b A=%0d B=%0d, expected 1 0 0", A_rd_en, A_rd_addr, B_rd_addr);
        end
        run_job(2000, 0, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 512 || dc != 1) begin
            errors++;
            $display("FAIL restart_run got timeout=%b beats=%0d done=%0d, expected 0 512 1", to, beat_idx, dc);
        end
    endtask

    task automatic test_start_while_busy;
        int dc, de;
        bit bd, to;
        build_model(16);
        @(posedge clk);
        #1;
        N_in = 16;
        start = 1'b1;
        run_job(2000, 3, -1, dc, de, bd, to);
        checks++;
        if (to || beat_idx != 512 || issue_idx != 512 || dc != 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL busy_start got timeout=%b beats=%0d reads=%0d done=%0d err=%b, expected 0 512 512 1 0",
                     to, beat_idx, issue_idx, dc, err);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_cfg();
        test_reset_mid();
        test_start_while_busy();
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
